// File: rtl/vga_sync_gen_pkg.sv
// VGA 640x480@60 timing constants and shared types for the sync generator
// and the draw stages that consume its coordinates.
package vga_sync_gen_pkg;

  localparam int COORD_W = 10;
  localparam int FCNT_W  = 16;

  localparam int VGA_H_ACT   = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SYNC  = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_H_TOTAL = VGA_H_ACT + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACT   = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SYNC  = 2;
  localparam int VGA_V_BP    = 33;
  localparam int VGA_V_TOTAL = VGA_V_ACT + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Output levels that travel together through the sync delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_t;

  function automatic logic in_window(logic [COORD_W-1:0] val, int lo, int hi);
    return (int'(val) >= lo) && (int'(val) <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Video timing bus between the sync generator (master) and a draw stage (slave).
interface vga_sync_gen_if;
  import vga_sync_gen_pkg::*;

  logic               pix_ce;
  logic [COORD_W-1:0] px_x;
  logic [COORD_W-1:0] px_y;
  logic               px_act;
  logic               HS;
  logic               VS;
  logic               de;
  logic               frame_start;
  logic               vblank_start;
  logic [FCNT_W-1:0]  frame_cnt;

  modport master (
    input  pix_ce,
    output px_x, px_y, px_act, HS, VS, de, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    output pix_ce,
    input  px_x, px_y, px_act, HS, VS, de, frame_start, vblank_start, frame_cnt
  );

endinterface

// File: rtl/vga_sync_gen_sync_delay.sv
// Clock-enable qualified shift register used to line sync/de up with the
// downstream RGB pipeline; DEPTH = 0 is a straight wire.
module vga_sync_gen_sync_delay #(
  parameter int               WIDTH = 3,
  parameter int               DEPTH = 1,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, ce};
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: this array is reset on purpose -- every stage must hold the
      // inactive sync level after reset, so it cannot map to plain RAM.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
        end else if (ce) begin
          stage[0] <= d;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign q = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: h/v counters, registered coordinate and pulse decodes,
// frame counter, and a delayed HS/VS/de path matching the RGB pipeline.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int H_ACT    = VGA_H_ACT,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACT    = VGA_V_ACT,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter bit SYNC_POL = 1'b0,
  parameter int PIPE_DLY = 1
) (
  input logic            clk,
  input logic            rst,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;
  localparam sync_t SYNC_IDLE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0};

  logic [COORD_W-1:0] h;
  logic [COORD_W-1:0] v;
  logic               h_last;
  logic               v_last;
  logic               at_origin;
  logic               at_vblank;
  sync_t              sync_raw;
  sync_t              sync_q;
  sync_t              sync_dly;
  logic [FCNT_W-1:0]  frame_cnt_q;
  logic               cnt_armed;

  // NOTE: every output is assigned on every pass, so no latch can be inferred.
  always_comb begin
    h_last      = (h == COORD_W'(H_TOTAL - 1));
    v_last      = (v == COORD_W'(V_TOTAL - 1));
    at_origin   = (h == '0) && (v == '0);
    at_vblank   = (h == '0) && (v == COORD_W'(V_ACT));
    sync_raw.hs = in_window(h, H_ACT + H_FP, H_ACT + H_FP + H_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
    sync_raw.vs = in_window(v, V_ACT + V_FP, V_ACT + V_FP + V_SYNC - 1) ? SYNC_POL : ~SYNC_POL;
    sync_raw.de = (h < COORD_W'(H_ACT)) && (v < COORD_W'(V_ACT));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (bus.pix_ce) begin
      if (h_last) begin
        h <= '0;
        v <= v_last ? '0 : v + COORD_W'(1);
      end else begin
        h <= h + COORD_W'(1);
      end
    end
  end

  // Pulses update every clk so they last one cycle even when pix_ce stays high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.px_x         <= '0;
      bus.px_y         <= '0;
      bus.px_act       <= 1'b0;
      sync_q           <= SYNC_IDLE;
      bus.frame_start  <= 1'b0;
      bus.vblank_start <= 1'b0;
      frame_cnt_q      <= '0;
      cnt_armed        <= 1'b0;
    end else begin
      bus.frame_start  <= bus.pix_ce && at_origin;
      bus.vblank_start <= bus.pix_ce && at_vblank;
      if (bus.pix_ce) begin
        bus.px_x   <= h;
        bus.px_y   <= v;
        bus.px_act <= sync_raw.de;
        sync_q     <= sync_raw;
        // The frame_start at reset exit only arms the counter.
        if (at_origin) begin
          cnt_armed <= 1'b1;
          if (cnt_armed) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
        end
      end
    end
  end

  vga_sync_gen_sync_delay #(
    .WIDTH ($bits(sync_t)),
    .DEPTH (PIPE_DLY),
    .INIT  (SYNC_IDLE)
  ) u_sync_delay (
    .clk (clk),
    .rst (rst),
    .ce  (bus.pix_ce),
    .d   (sync_q),
    .q   (sync_dly)
  );

  assign bus.HS        = sync_dly.hs;
  assign bus.VS        = sync_dly.vs;
  assign bus.de        = sync_dly.de;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size timing for line-level checks (PIPE_DLY 0 and 2),
// and a shrunken 16x10 raster (PIPE_DLY 1) for frame-level checks.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  int   cycle = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  vga_sync_gen_if bus_a ();
  vga_sync_gen_if bus_b ();
  vga_sync_gen_if bus_s ();
  assign bus_a.pix_ce = ce;
  assign bus_b.pix_ce = ce;
  assign bus_s.pix_ce = ce;

  vga_sync_gen #(.PIPE_DLY(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  vga_sync_gen #(.PIPE_DLY(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  // Small raster: H 8+2+3+3 = 16, V 6+1+2+1 = 10, frame = 160 steps.
  vga_sync_gen #(
    .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .PIPE_DLY(1)
  ) dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    ce  = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++; if ({bus_a.HS, bus_a.VS, bus_a.de} !== 3'b110) begin n_err++;
      $display("FAIL reset_sync_a: got %b want 110", {bus_a.HS, bus_a.VS, bus_a.de}); end
    n_cmp++; if ({bus_b.HS, bus_b.VS, bus_b.de} !== 3'b110) begin n_err++;
      $display("FAIL reset_sync_b: got %b want 110", {bus_b.HS, bus_b.VS, bus_b.de}); end
    n_cmp++; if (bus_a.frame_cnt !== 16'd0) begin n_err++;
      $display("FAIL reset_frame_cnt: got %0d want 0", bus_a.frame_cnt); end
    n_cmp++; if ({bus_a.px_x, bus_a.px_y, bus_a.px_act} !== 21'd0) begin n_err++;
      $display("FAIL reset_px: got x=%0d y=%0d act=%b want 0/0/0", bus_a.px_x, bus_a.px_y, bus_a.px_act); end
    repeat (5) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (bus_a.px_x !== 10'(k)) begin n_err++;
        $display("FAIL release_px_x[%0d]: got %0d want %0d", k, bus_a.px_x, k); end
      if (k == 0) begin
        n_cmp++; if (bus_a.frame_start !== 1'b1) begin n_err++;
          $display("FAIL first_frame_start: got %b want 1", bus_a.frame_start); end
        n_cmp++; if (bus_a.frame_cnt !== 16'd0) begin n_err++;
          $display("FAIL first_frame_uncounted: got %0d want 0", bus_a.frame_cnt); end
      end
      if (k == 1) begin
        n_cmp++; if (bus_a.frame_start !== 1'b0) begin n_err++;
          $display("FAIL frame_start_width: got %b want 0", bus_a.frame_start); end
      end
    end
  endtask

  task automatic test_hsync();
    bit found = 1'b0;
    int low = 1;
    int de_hi = 0;
    int act_bad = 0;
    int t0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (bus_a.HS === 1'b0) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL hs_fall_timeout: got none want fall"); end
    n_cmp++; if (bus_a.px_x !== 10'd656 || bus_a.px_y !== 10'd0) begin n_err++;
      $display("FAIL hs_fall_pos: got x=%0d y=%0d want 656/0", bus_a.px_x, bus_a.px_y); end
    t0 = cycle;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus_a.HS === 1'b0) low++; else break;
    end
    n_cmp++; if (low != 96) begin n_err++; $display("FAIL hs_width: got %0d want 96", low); end
    found = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (bus_a.de === 1'b1) de_hi++;
      if (bus_a.de !== bus_a.px_act) act_bad++;
      if (bus_a.HS === 1'b0) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found || cycle - t0 != 800) begin n_err++;
      $display("FAIL line_period: got %0d want 800", cycle - t0); end
    n_cmp++; if (bus_a.px_y !== 10'd1) begin n_err++;
      $display("FAIL line_advance: got y=%0d want 1", bus_a.px_y); end
    n_cmp++; if (de_hi != 640) begin n_err++; $display("FAIL de_per_line: got %0d want 640", de_hi); end
    n_cmp++; if (act_bad != 0) begin n_err++;
      $display("FAIL de_vs_px_act_dly0: got %0d differing cycles want 0", act_bad); end
  endtask

  task automatic test_pipe_dly();
    logic [2:0] p1 = 3'b110;
    logic [2:0] p2 = 3'b110;
    logic [2:0] now_a;
    logic       b_prev = bus_b.HS;
    int sync_bad = 0;
    int px_bad = 0;
    int fall_x = -1;
    for (int k = 0; k < 1700; k++) begin
      @(negedge clk);
      now_a = {bus_a.HS, bus_a.VS, bus_a.de};
      if (k >= 2 && {bus_b.HS, bus_b.VS, bus_b.de} !== p2) sync_bad++;
      if (bus_b.px_x !== bus_a.px_x || bus_b.px_y !== bus_a.px_y) px_bad++;
      if (fall_x < 0 && b_prev === 1'b1 && bus_b.HS === 1'b0) fall_x = int'(bus_b.px_x);
      b_prev = bus_b.HS;
      p2 = p1;
      p1 = now_a;
    end
    n_cmp++; if (sync_bad != 0) begin n_err++;
      $display("FAIL dly2_shifted_copy: got %0d differing cycles want 0", sync_bad); end
    n_cmp++; if (px_bad != 0) begin n_err++;
      $display("FAIL dly2_px_unchanged: got %0d differing cycles want 0", px_bad); end
    n_cmp++; if (fall_x != 658) begin n_err++;
      $display("FAIL dly2_hs_fall_x: got %0d want 658", fall_x); end
  endtask

  task automatic test_frame();
    bit found = 1'b0;
    int t0;
    int vs_low = 0, hs_low = 0, de_hi = 0, vb_n = 0;
    int vb_x = -1, vb_y = -1, vf_x = -1, vf_y = -1;
    logic [15:0] fc0;
    logic vs_prev;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_s.frame_start === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL frame_start_timeout: got none want pulse"); end
    n_cmp++; if (bus_s.px_x !== 10'd0 || bus_s.px_y !== 10'd0) begin n_err++;
      $display("FAIL frame_start_pos: got x=%0d y=%0d want 0/0", bus_s.px_x, bus_s.px_y); end
    t0 = cycle;
    fc0 = bus_s.frame_cnt;
    vs_prev = bus_s.VS;
    found = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_s.VS === 1'b0) vs_low++;
      if (bus_s.HS === 1'b0) hs_low++;
      if (bus_s.de === 1'b1) de_hi++;
      if (bus_s.vblank_start === 1'b1) begin
        vb_n++; vb_x = int'(bus_s.px_x); vb_y = int'(bus_s.px_y);
      end
      if (vs_prev === 1'b1 && bus_s.VS === 1'b0) begin
        vf_x = int'(bus_s.px_x); vf_y = int'(bus_s.px_y);
      end
      vs_prev = bus_s.VS;
      if (bus_s.frame_start === 1'b1) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found || cycle - t0 != 160) begin n_err++;
      $display("FAIL frame_period: got %0d want 160", cycle - t0); end
    n_cmp++; if (bus_s.frame_cnt !== 16'(fc0 + 16'd1)) begin n_err++;
      $display("FAIL frame_cnt_step: got %0d want %0d", bus_s.frame_cnt, 16'(fc0 + 16'd1)); end
    n_cmp++; if (vs_low != 32) begin n_err++; $display("FAIL vs_low_per_frame: got %0d want 32", vs_low); end
    n_cmp++; if (hs_low != 30) begin n_err++; $display("FAIL hs_low_per_frame: got %0d want 30", hs_low); end
    n_cmp++; if (de_hi != 48) begin n_err++; $display("FAIL de_per_frame: got %0d want 48", de_hi); end
    n_cmp++; if (vb_n != 1 || vb_x != 0 || vb_y != 6) begin n_err++;
      $display("FAIL vblank_start: got n=%0d x=%0d y=%0d want 1/0/6", vb_n, vb_x, vb_y); end
    n_cmp++; if (vf_x != 1 || vf_y != 7) begin n_err++;
      $display("FAIL vs_fall_pos_dly1: got x=%0d y=%0d want 1/7", vf_x, vf_y); end
  endtask

  task automatic test_ce_div4();
    logic       prev_ce = 1'b1;
    logic [9:0] x_prev = '0, y_prev = '0;
    logic [2:0] s_prev = '0;
    logic [15:0] c_prev = '0, fc1 = '0, fc2 = '0;
    logic       fs_prev = 1'b0;
    int pulses = 0, t1 = 0, t2 = 0, hold_bad = 0, width_bad = 0, hs_low = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (k > 0) begin
        if (!prev_ce && (bus_s.px_x !== x_prev || bus_s.px_y !== y_prev ||
            {bus_s.HS, bus_s.VS, bus_s.de} !== s_prev || bus_s.frame_cnt !== c_prev ||
            bus_s.frame_start !== 1'b0 || bus_s.vblank_start !== 1'b0)) hold_bad++;
        if (fs_prev === 1'b1 && bus_s.frame_start === 1'b1) width_bad++;
        if (pulses == 1 && bus_s.HS === 1'b0) hs_low++;
        if (bus_s.frame_start === 1'b1) begin
          pulses++;
          if (pulses == 1) begin t1 = cycle; fc1 = bus_s.frame_cnt; end
          if (pulses == 2) begin t2 = cycle; fc2 = bus_s.frame_cnt; end
        end
      end
      if (pulses >= 2) break;
      x_prev = bus_s.px_x; y_prev = bus_s.px_y; c_prev = bus_s.frame_cnt;
      s_prev = {bus_s.HS, bus_s.VS, bus_s.de};
      fs_prev = bus_s.frame_start;
      prev_ce = (k % 4 == 0);
      ce = prev_ce;
    end
    ce = 1'b1;
    n_cmp++; if (pulses < 2 || t2 - t1 != 640) begin n_err++;
      $display("FAIL div4_frame_period: got %0d (pulses %0d) want 640", t2 - t1, pulses); end
    n_cmp++; if (fc2 !== 16'(fc1 + 16'd1)) begin n_err++;
      $display("FAIL div4_frame_cnt: got %0d want %0d", fc2, 16'(fc1 + 16'd1)); end
    n_cmp++; if (hs_low != 120) begin n_err++; $display("FAIL div4_hs_low: got %0d want 120", hs_low); end
    n_cmp++; if (hold_bad != 0) begin n_err++;
      $display("FAIL div4_hold: got %0d changed idle cycles want 0", hold_bad); end
    n_cmp++; if (width_bad != 0) begin n_err++;
      $display("FAIL div4_pulse_width: got %0d wide pulses want 0", width_bad); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    ce = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (bus_s.px_y === 10'd3 && bus_s.px_x === 10'd5) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_err++; $display("FAIL mid_frame_timeout: got none want y=3"); end
    n_cmp++; if (bus_s.frame_cnt === 16'd0) begin n_err++;
      $display("FAIL pre_reset_frame_cnt: got 0 want nonzero"); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if ({bus_s.px_x, bus_s.px_y, bus_s.px_act} !== 21'd0) begin n_err++;
      $display("FAIL async_reset_px: got x=%0d y=%0d act=%b want 0/0/0", bus_s.px_x, bus_s.px_y, bus_s.px_act); end
    n_cmp++; if ({bus_s.HS, bus_s.VS, bus_s.de, bus_s.frame_start} !== 4'b1100) begin n_err++;
      $display("FAIL async_reset_sync: got %b want 1100", {bus_s.HS, bus_s.VS, bus_s.de, bus_s.frame_start}); end
    n_cmp++; if (bus_s.frame_cnt !== 16'd0) begin n_err++;
      $display("FAIL async_reset_frame_cnt: got %0d want 0", bus_s.frame_cnt); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_s.frame_start !== 1'b1 || bus_s.frame_cnt !== 16'd0) begin n_err++;
      $display("FAIL restart_frame_start: got fs=%b cnt=%0d want 1/0", bus_s.frame_start, bus_s.frame_cnt); end
    @(negedge clk);
    n_cmp++; if (bus_s.px_x !== 10'd1 || bus_s.frame_start !== 1'b0) begin n_err++;
      $display("FAIL restart_step: got x=%0d fs=%b want 1/0", bus_s.px_x, bus_s.frame_start); end
    force dut_s.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut_s.frame_cnt_q;
    for (int n = 0; n < 2; n++) begin
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
        @(negedge clk);
        if (bus_s.frame_start === 1'b1) begin found = 1'b1; break; end
      end
      n_cmp++; if (!found || bus_s.frame_cnt !== 16'(n)) begin n_err++;
        $display("FAIL frame_cnt_wrap[%0d]: got %0d want %0d", n, bus_s.frame_cnt, n); end
    end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_pipe_dly();
    test_frame();
    test_ce_div4();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
